// File: rtl/reg_scoreboard_pkg.sv
// Shared types and constants for the register-hazard scoreboard.
// Register codes are 4 bits; RAX/RDX name the IMUL/DIV destination pair.
package reg_scoreboard_pkg;

   localparam int NUM_GPR = 16;

   typedef logic [3:0] reg_code_t;

   localparam reg_code_t REG_RAX = 4'd0;
   localparam reg_code_t REG_RDX = 4'd2;

endpackage

// File: rtl/reg_scoreboard_stall_watchdog.sv
// Saturating count of consecutive stalled cycles.
// The sticky deadlock flag rises once the count reaches STALL_TIMEOUT.
module stall_watchdog #(
   parameter int STALL_TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic stall,
   output logic deadlock
);

   localparam logic [15:0] LIMIT = 16'(STALL_TIMEOUT);

   logic [15:0] count;

   // The flag is set on the same edge that brings the count up to LIMIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         deadlock <= 1'b0;
      end else if (stall) begin
         if (count != LIMIT) begin
            count <= count + 16'd1;
         end
         if (count >= LIMIT - 16'd1) begin
            deadlock <= 1'b1;
         end
      end else begin
         count <= '0;
      end
   end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard feeding the operand-read stage stall input.
// Tracks in-flight GPR writes from issue until writeback.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int NUM_REGS      = NUM_GPR,
   parameter int STALL_TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                canReadIn,
   input  reg_code_t           sourceReg1In,
   input  logic                sourceReg1ValidIn,
   input  reg_code_t           sourceReg2In,
   input  logic                sourceReg2ValidIn,
   input  reg_code_t           destRegIn,
   input  logic                destRegValidIn,
   input  reg_code_t           destRegisterSpecialIn,
   input  logic                destRegisterSpecialValidIn,
   input  logic                isReadSuccessfulIn,
   input  logic                wbValidIn,
   input  reg_code_t           wbRegIn,
   input  logic                wbSpecialValidIn,
   input  reg_code_t           wbSpecialRegIn,
   input  logic                flushIn,
   output logic                hazardStallOut,
   output logic [NUM_REGS-1:0] pendingMaskOut,
   output logic                busyOut,
   output logic                errorOut,
   output logic                deadlockOut
);

   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] setMask;
   logic [NUM_REGS-1:0] clearMask;
   logic                hazard;
   logic                issue;
   logic                protocolError;

   // Stall looks at registered state only, so a same-cycle writeback
   // still stalls and releases on the following cycle.
   always_comb begin
      hazard        = (sourceReg1ValidIn          && pending[sourceReg1In])
                   || (sourceReg2ValidIn          && pending[sourceReg2In])
                   || (destRegValidIn             && pending[destRegIn])
                   || (destRegisterSpecialValidIn && pending[destRegisterSpecialIn]);
      issue         = isReadSuccessfulIn && !(canReadIn && hazard);
      setMask       = '0;
      clearMask     = '0;
      if (issue && destRegValidIn) begin
         setMask[destRegIn] = 1'b1;
      end
      if (issue && destRegisterSpecialValidIn) begin
         setMask[destRegisterSpecialIn] = 1'b1;
      end
      if (wbValidIn) begin
         clearMask[wbRegIn] = 1'b1;
      end
      if (wbSpecialValidIn) begin
         clearMask[wbSpecialRegIn] = 1'b1;
      end
      protocolError = (isReadSuccessfulIn && canReadIn && hazard)
                   || (wbValidIn        && !pending[wbRegIn])
                   || (wbSpecialValidIn && !pending[wbSpecialRegIn]);
   end

   // Set is applied after clear so a younger issue wins over a retiring write.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending  <= '0;
         errorOut <= 1'b0;
      end else if (flushIn) begin
         pending  <= '0;
      end else begin
         pending <= (pending & ~clearMask) | setMask;
         if (protocolError) begin
            errorOut <= 1'b1;
         end
      end
   end

   assign hazardStallOut = canReadIn && hazard;
   assign pendingMaskOut = pending;
   assign busyOut        = |pending;

   stall_watchdog #(
      .STALL_TIMEOUT(STALL_TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .stall   (hazardStallOut),
      .deadlock(deadlockOut)
   );

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vectors plus a per-cycle
// comparison against a set-based model of the pending registers.
module tb_reg_scoreboard;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        canReadIn;
   logic [3:0]  sourceReg1In, sourceReg2In, destRegIn, destRegisterSpecialIn;
   logic [3:0]  wbRegIn, wbSpecialRegIn;
   logic        sourceReg1ValidIn, sourceReg2ValidIn, destRegValidIn;
   logic        destRegisterSpecialValidIn, isReadSuccessfulIn;
   logic        wbValidIn, wbSpecialValidIn, flushIn;
   logic        hazardStallOut, busyOut, errorOut, deadlockOut;
   logic [15:0] pendingMaskOut;

   int checks   = 0;
   int failures = 0;

   bit modelPending [16];
   bit modelError;
   bit modelDeadlock;
   int modelStallRun;
   bit started = 1'b0;

   always #5 clk = ~clk;

   reg_scoreboard #(.NUM_REGS(16), .STALL_TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .canReadIn(canReadIn),
      .sourceReg1In(sourceReg1In), .sourceReg1ValidIn(sourceReg1ValidIn),
      .sourceReg2In(sourceReg2In), .sourceReg2ValidIn(sourceReg2ValidIn),
      .destRegIn(destRegIn), .destRegValidIn(destRegValidIn),
      .destRegisterSpecialIn(destRegisterSpecialIn),
      .destRegisterSpecialValidIn(destRegisterSpecialValidIn),
      .isReadSuccessfulIn(isReadSuccessfulIn),
      .wbValidIn(wbValidIn), .wbRegIn(wbRegIn),
      .wbSpecialValidIn(wbSpecialValidIn), .wbSpecialRegIn(wbSpecialRegIn),
      .flushIn(flushIn), .hazardStallOut(hazardStallOut),
      .pendingMaskOut(pendingMaskOut), .busyOut(busyOut),
      .errorOut(errorOut), .deadlockOut(deadlockOut)
   );

   function automatic bit modelStall();
      bit need = 1'b0;
      if (sourceReg1ValidIn && modelPending[sourceReg1In]) need = 1'b1;
      if (sourceReg2ValidIn && modelPending[sourceReg2In]) need = 1'b1;
      if (destRegValidIn && modelPending[destRegIn]) need = 1'b1;
      if (destRegisterSpecialValidIn && modelPending[destRegisterSpecialIn]) need = 1'b1;
      return canReadIn && need;
   endfunction

   function automatic logic [15:0] modelMask();
      logic [15:0] m = '0;
      for (int i = 0; i < 16; i++) if (modelPending[i]) m = m | (16'd1 << i);
      return m;
   endfunction

   // Model: a set of pending registers updated once per cycle.
   always @(posedge clk) begin
      bit stallNow;
      bit old [16];
      stallNow = modelStall();
      if (reset) begin
         for (int i = 0; i < 16; i++) modelPending[i] = 1'b0;
         modelError = 1'b0;
         modelDeadlock = 1'b0;
         modelStallRun = 0;
      end else begin
         if (flushIn) begin
            for (int i = 0; i < 16; i++) modelPending[i] = 1'b0;
         end else begin
            old = modelPending;
            if (isReadSuccessfulIn && stallNow) modelError = 1'b1;
            if (wbValidIn) begin
               if (!old[wbRegIn]) modelError = 1'b1;
               modelPending[wbRegIn] = 1'b0;
            end
            if (wbSpecialValidIn) begin
               if (!old[wbSpecialRegIn]) modelError = 1'b1;
               modelPending[wbSpecialRegIn] = 1'b0;
            end
            if (isReadSuccessfulIn && !stallNow) begin
               if (destRegValidIn) modelPending[destRegIn] = 1'b1;
               if (destRegisterSpecialValidIn) modelPending[destRegisterSpecialIn] = 1'b1;
            end
         end
         if (stallNow) begin
            if (modelStallRun < TIMEOUT) modelStallRun++;
            if (modelStallRun >= TIMEOUT) modelDeadlock = 1'b1;
         end else begin
            modelStallRun = 0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%04h expected 0x%04h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         checkOutput("model_stall", {15'd0, hazardStallOut}, {15'd0, modelStall()});
         checkOutput("model_mask", pendingMaskOut, modelMask());
         checkOutput("model_busy", {15'd0, busyOut}, {15'd0, (modelMask() != 16'd0)});
         checkOutput("model_error", {15'd0, errorOut}, {15'd0, modelError});
         checkOutput("model_deadlock", {15'd0, deadlockOut}, {15'd0, modelDeadlock});
      end
   end

   task automatic clearInputs();
      canReadIn = 0; isReadSuccessfulIn = 0; flushIn = 0;
      sourceReg1In = 0; sourceReg1ValidIn = 0;
      sourceReg2In = 0; sourceReg2ValidIn = 0;
      destRegIn = 0; destRegValidIn = 0;
      destRegisterSpecialIn = 0; destRegisterSpecialValidIn = 0;
      wbValidIn = 0; wbRegIn = 0; wbSpecialValidIn = 0; wbSpecialRegIn = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rd, input logic [3:0] dst,
                                input logic dstV, input logic [3:0] spc,
                                input logic spcV);
      isReadSuccessfulIn = rd;
      destRegIn = dst; destRegValidIn = dstV;
      destRegisterSpecialIn = spc; destRegisterSpecialValidIn = spcV;
   endtask

   initial begin
      clearInputs();
      reset = 1;
      tick();
      started = 1'b1;
      tick();
      reset = 0;
      checkOutput("reset_mask", pendingMaskOut, 16'h0000);
      checkOutput("reset_busy", {15'd0, busyOut}, 16'd0);
      checkOutput("reset_error", {15'd0, errorOut}, 16'd0);
      checkOutput("reset_deadlock", {15'd0, deadlockOut}, 16'd0);

      canReadIn = 1; sourceReg1In = 3; sourceReg1ValidIn = 1;
      #1 checkOutput("idle_stall", {15'd0, hazardStallOut}, 16'd0);

      // RAW on r5
      sourceReg1ValidIn = 0;
      applyStimulus(1, 5, 1, 0, 0);
      tick();
      clearInputs();
      checkOutput("issue5_mask", pendingMaskOut, 16'h0020);
      canReadIn = 1; sourceReg1In = 5; sourceReg1ValidIn = 1;
      #1 checkOutput("raw_stall", {15'd0, hazardStallOut}, 16'd1);
      wbValidIn = 1; wbRegIn = 5;
      #1 checkOutput("raw_stall_wb_cycle", {15'd0, hazardStallOut}, 16'd1);
      tick();
      wbValidIn = 0;
      #1 checkOutput("raw_release", {15'd0, hazardStallOut}, 16'd0);
      checkOutput("raw_mask", pendingMaskOut, 16'h0000);

      // IMUL writes RAX and RDX
      clearInputs();
      canReadIn = 1;
      applyStimulus(1, 0, 1, 2, 1);
      tick();
      clearInputs();
      checkOutput("imul_mask", pendingMaskOut, 16'h0005);
      checkOutput("imul_busy", {15'd0, busyOut}, 16'd1);
      canReadIn = 1; destRegIn = 2; destRegValidIn = 1;
      #1 checkOutput("waw_stall", {15'd0, hazardStallOut}, 16'd1);
      wbValidIn = 1; wbRegIn = 0; wbSpecialValidIn = 1; wbSpecialRegIn = 2;
      tick();
      wbValidIn = 0; wbSpecialValidIn = 0;
      checkOutput("imul_wb_mask", pendingMaskOut, 16'h0000);
      checkOutput("waw_release", {15'd0, hazardStallOut}, 16'd0);

      // Same-cycle issue and writeback of r7: set wins
      clearInputs();
      applyStimulus(1, 7, 1, 0, 0);
      tick();
      checkOutput("issue7_mask", pendingMaskOut, 16'h0080);
      wbValidIn = 1; wbRegIn = 7;
      tick();
      clearInputs();
      checkOutput("set_wins_mask", pendingMaskOut, 16'h0080);
      checkOutput("set_wins_no_error", {15'd0, errorOut}, 16'd0);
      wbValidIn = 1; wbRegIn = 9;
      tick();
      wbValidIn = 0;
      checkOutput("wb_unpending_error", {15'd0, errorOut}, 16'd1);
      checkOutput("wb_unpending_mask", pendingMaskOut, 16'h0080);
      wbValidIn = 1; wbRegIn = 7;
      tick();
      wbValidIn = 0;
      checkOutput("error_sticky", {15'd0, errorOut}, 16'd1);
      checkOutput("r7_retired", pendingMaskOut, 16'h0000);

      // Build 0x00FF, then flush with a simultaneous issue of r12
      for (int i = 0; i < 8; i += 2) begin
         applyStimulus(1, 4'(i), 1, 4'(i + 1), 1);
         tick();
      end
      clearInputs();
      checkOutput("fill_mask", pendingMaskOut, 16'h00FF);
      flushIn = 1;
      applyStimulus(1, 12, 1, 0, 0);
      tick();
      clearInputs();
      checkOutput("flush_mask", pendingMaskOut, 16'h0000);
      checkOutput("flush_keeps_error", {15'd0, errorOut}, 16'd1);

      // Watchdog and issue-while-stalled
      reset = 1;
      tick();
      reset = 0;
      checkOutput("reset2_error", {15'd0, errorOut}, 16'd0);
      applyStimulus(1, 4, 1, 0, 0);
      tick();
      clearInputs();
      canReadIn = 1; sourceReg1In = 4; sourceReg1ValidIn = 1;
      isReadSuccessfulIn = 1; destRegIn = 6; destRegValidIn = 1;
      tick();
      isReadSuccessfulIn = 0; destRegValidIn = 0;
      checkOutput("issue_while_stalled_error", {15'd0, errorOut}, 16'd1);
      checkOutput("issue_while_stalled_mask", pendingMaskOut, 16'h0010);
      tick();
      tick();
      checkOutput("deadlock_after_3", {15'd0, deadlockOut}, 16'd0);
      tick();
      checkOutput("deadlock_after_4", {15'd0, deadlockOut}, 16'd1);
      canReadIn = 0;
      tick();
      tick();
      checkOutput("deadlock_sticky", {15'd0, deadlockOut}, 16'd1);
      reset = 1;
      tick();
      reset = 0;
      checkOutput("deadlock_cleared", {15'd0, deadlockOut}, 16'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register-hazard scoreboard that sits directly upstream of the operand-read stage and drives its stall input.
- Tracks which of the 16 GPRs have an in-flight write, from a successful read/issue until writeback.
- Holds the read stage while any source, destination or special-destination register it needs is pending.
- Includes a stall watchdog and sticky error reporting for verification and debug.

Parameters:
- NUM_REGS, 16, number of architectural GPRs tracked; register codes are 4 bits.
- STALL_TIMEOUT, 255, consecutive stalled cycles before deadlockOut is set; range 1..65535.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- canReadIn  in  1  read stage holds a valid decoded instruction.
- sourceReg1In  in  [0:3]  source register 1 code.
- sourceReg1ValidIn  in  1  source 1 is a register.
- sourceReg2In  in  [0:3]  source register 2 code.
- sourceReg2ValidIn  in  1  source 2 is a register.
- destRegIn  in  [0:3]  destination register code.
- destRegValidIn  in  1  destination is a register.
- destRegisterSpecialIn  in  [0:3]  second destination (RDX of IMUL/DIV).
- destRegisterSpecialValidIn  in  1  second destination valid.
- isReadSuccessfulIn  in  1  read stage accepted the instruction this cycle (issue event).
- wbValidIn  in  1  writeback retires a write to wbRegIn.
- wbRegIn  in  [0:3]  writeback register code.
- wbSpecialValidIn  in  1  writeback retires a write to wbSpecialRegIn.
- wbSpecialRegIn  in  [0:3]  special writeback register code.
- flushIn  in  1  pipeline flush; discard all pending entries.
- hazardStallOut  out  1  combinational stall to the read stage.
- pendingMaskOut  out  [15:0]  registered pending bit per register; bit i = register i.
- busyOut  out  1  any pending bit set.
- errorOut  out  1  sticky protocol error.
- deadlockOut  out  1  sticky watchdog expiry.

Behaviour:
- Reset: pending mask 0, errorOut 0, deadlockOut 0, stall counter 0. hazardStallOut and busyOut derive from this state, so both are 0.
- hazardStallOut = canReadIn && (any valid src1/src2/dest/special code has its pending bit set).
  - Evaluated from registered state only; there is no same-cycle writeback bypass.
  - A register being written back this cycle still stalls; the stall releases the next cycle.
- Issue event: isReadSuccessfulIn && !hazardStallOut. At the next edge, set pending[destRegIn] if destRegValidIn, and pending[destRegisterSpecialIn] if its valid is set.
  - Dest equal to special dest sets one bit.
- Writeback: clear pending[wbRegIn] if wbValidIn; clear pending[wbSpecialRegIn] if wbSpecialValidIn.
- Same register issued and written back in the same cycle: the set wins, because the new write is younger.
- Writeback to a register whose pending bit is 0: bit stays 0, errorOut set.
- isReadSuccessfulIn while hazardStallOut = 1: no state change, errorOut set.
- flushIn: next cycle pending mask = 0. Issue and writeback in the same cycle are ignored. errorOut and deadlockOut are kept.
- reset has priority over flushIn, and flushIn over issue and writeback.
- Watchdog: counter increments each cycle hazardStallOut = 1 and clears to 0 on any cycle it is 0.
  - On reaching STALL_TIMEOUT, deadlockOut is set; the counter saturates.
- errorOut and deadlockOut clear only on reset.
- Latency: issue to visible pending bit is 1 cycle; writeback to stall release is 1 cycle.

Decomposition:
- Shared package: reg_code_t (4-bit), NUM_GPR = 16, and named constants REG_RAX = 0 and REG_RDX = 2 for the special-destination convention.
- Natural sub-module: stall_watchdog (saturating counter plus sticky flag), parameterised by STALL_TIMEOUT.
- The pending-mask logic stays in the top module.

Test Plan:
- Reset, then canReadIn = 1, src1 = 3 valid, nothing pending -> hazardStallOut = 0, pendingMaskOut = 0x0000.
- Issue dest = 5 (RAW): next cycle src1 = 5 -> hazardStallOut = 1. wbValidIn with wbRegIn = 5 -> stall still 1 that cycle, 0 the following cycle, pendingMaskOut = 0x0000.
- Issue IMUL dest = 0 with special = 2 -> pendingMaskOut = 0x0005, busyOut = 1. A later instruction with dest = 2 stalls (WAW). Writeback of 0 and 2 -> mask 0x0000.
- Same-cycle issue dest = 7 and writeback 7 while bit 7 is already set -> bit 7 stays 1. Writeback of 9 while not pending -> errorOut = 1 and stays 1.
- Mask 0x00FF, then flushIn together with an issue of dest = 12 -> next cycle mask 0x0000, bit 12 clear.
- STALL_TIMEOUT = 4, src1 held pending with no writeback -> deadlockOut rises after exactly 4 stalled cycles. Reset clears it.
